pc_unit: RTL and testbench
==========================

// Module: pc_unit
// PURPOSE
//  Parametrised program-counter unit for the fetch stage; next generation of the plain PC register.
//  Holds PC; next PC is one of: sequential increment, PC-relative branch, absolute jump, trap vector or exception return.
//  Adds stall, alignment checking, a RUN/HANDLER trap state machine with EPC capture, and an optional return-address stack (RAS).
// PARAMETERS
//  N          32       PC/address width
//  INC        4        sequential increment in bytes
//  ALIGN      2        low PC bits that must be zero (targets)
//  RESET_VEC  32'h0    PC value while/after reset
//  TRAP_VEC   32'h100  trap handler entry address
//  RAS_DEPTH  4        RAS entries (power of 2, >=2; used only with PC_RAS_EN)
// PORTS
//  clk          in   1  clock, all state updates on posedge
//  rst_n        in   1  asynchronous, active-low reset
//  stall        in   1  hold PC/state/RAS this cycle
//  br_taken     in   1  take PC-relative branch
//  br_offset    in   N  signed byte offset, added to current pc
//  jmp_valid    in   1  absolute jump
//  jmp_target   in   N  jump destination
//  call         in   1  with jmp_valid: push pc_plus onto RAS
//  ret          in   1  jump to popped RAS top
//  trap         in   1  exception request
//  eret         in   1  return from handler
//  pc           out  N  current PC
//  pc_plus      out  N  pc + INC (combinational)
//  epc          out  N  saved exception PC
//  in_handler   out  1  1 while in HANDLER state
//  misaligned   out  1  1-cycle pulse: redirect target misaligned
//  double_fault out  1  1-cycle pulse: trap taken while in HANDLER
//  ras_empty    out  1  RAS has no entries (1 when PC_RAS_EN off)
//  ras_err      out  1  1-cycle pulse: ret on empty RAS
// BEHAVIOUR
//  Reset (rst_n=0, async): pc=RESET_VEC, epc=0, state=RUN, RAS count=0, all pulses 0.
//  Next-PC priority per cycle, highest first: trap > eret > stall > ret > jmp_valid > br_taken > pc+INC.
//  Latency: selected target appears on pc one cycle after the request edge; no bubbles.
//  Arithmetic modulo 2^N; pc+INC and pc+br_offset wrap silently (0xFFFFFFFC+4 -> 0).
//  States: RUN, HANDLER.
//   RUN + trap: epc<=pc, pc<=TRAP_VEC, ->HANDLER.
//   HANDLER + trap: pc<=TRAP_VEC, epc kept, double_fault=1, stay HANDLER.
//   HANDLER + eret: pc<=epc, ->RUN.  RUN + eret: ignored (falls to lower priorities).
//  trap/eret act even when stall=1; stall otherwise freezes pc, state and RAS.
//  Alignment: ret/jmp/br target with target[ALIGN-1:0]!=0 -> not taken; handled as trap
//   (same state rules as trap), misaligned=1 next cycle; no RAS push/pop occurs.
//  Outputs misaligned/double_fault/ras_err registered, high exactly one cycle.
// CONFIGURATION
//  PC_RAS_EN defined: RAS_DEPTH-entry circular stack.
//   jmp_valid&call push pc_plus; push when full overwrites oldest entry.
//   ret pops top as target; ret on empty: no redirect, pc<=pc+INC, ras_err=1.
//   Simultaneous call+ret: ret wins, no push. Trap never alters RAS.
//  PC_RAS_EN undefined: no RAS storage; call ignored (plain jump); ret ignored
//   (lower priorities apply); ras_empty=1, ras_err=0 constant.
// TESTING (N=32, INC=4, ALIGN=2, RESET_VEC=0, TRAP_VEC=0x100)
//  Deassert rst_n, 3 idle cycles -> pc 0,4,8,0xC; assert rst_n=0 mid-cycle -> pc=0 immediately.
//  pc=0x20, br_taken, br_offset=-8 -> pc=0x18; stall=1 two cycles -> pc stays 0x18.
//  pc=0x40, trap -> pc=0x100, epc=0x40, in_handler=1; trap again -> double_fault pulse, epc=0x40; eret -> pc=0x40.
//  pc=0x50, jmp_target=0x62 -> pc=0x100, epc=0x50, misaligned pulse; RUN+eret at pc=0x0 -> pc=0x4.
//  PC_RAS_EN: call to 0x200 from pc=0x10, call to 0x300 -> ret -> pc=0x204, ret -> pc=0x14, ret -> ras_err, pc=0x18.
//  pc=0xFFFFFFFC, no request -> pc=0; PC_RAS_EN, 5 calls with depth 4 -> 4 rets return the newest 4 addresses.

Source files
------------

// File: rtl/pc_unit.sv
// Fetch-stage program counter: sequential/branch/jump/trap/eret next-PC selection with a RUN/HANDLER trap FSM.
// Optional return-address stack enabled by defining PC_RAS_EN.
module pc_unit #(
    parameter int          N         = 32,
    parameter int          INC       = 4,
    parameter int          ALIGN     = 2,
    parameter logic [N-1:0] RESET_VEC = 32'h0,
    parameter logic [N-1:0] TRAP_VEC  = 32'h100,
    parameter int          RAS_DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         stall,
    input  logic         br_taken,
    input  logic [N-1:0] br_offset,
    input  logic         jmp_valid,
    input  logic [N-1:0] jmp_target,
    input  logic         call,
    input  logic         ret,
    input  logic         trap,
    input  logic         eret,
    output logic [N-1:0] pc,
    output logic [N-1:0] pc_plus,
    output logic [N-1:0] epc,
    output logic         in_handler,
    output logic         misaligned,
    output logic         double_fault,
    output logic         ras_empty,
    output logic         ras_err
);

    localparam logic [N-1:0] INC_V      = N'(INC);
    localparam logic [N-1:0] ALIGN_MASK = (N'(1) << ALIGN) - N'(1);

`ifdef PC_RAS_EN
    localparam logic RAS_ON = 1'b1;
`else
    localparam logic RAS_ON = 1'b0;
`endif

    typedef enum logic [0:0] {ST_RUN = 1'b0, ST_HANDLER = 1'b1} state_t;

    function automatic logic is_misaligned(input logic [N-1:0] addr);
        return (addr & ALIGN_MASK) != {N{1'b0}};
    endfunction

    state_t       state_r, state_nxt_s;
    logic [N-1:0] pc_r, pc_nxt_s, epc_r, epc_nxt_s;
    logic [N-1:0] pc_plus_s, br_target_s, ras_top_s;
    logic         mis_r, mis_nxt_s, df_r, df_nxt_s, rerr_r, rerr_nxt_s;
    logic         push_s, pop_s, take_trap_s, ret_act_s, ras_empty_s;

    assign pc_plus_s   = pc_r + INC_V;
    assign br_target_s = pc_r + br_offset;
    assign ret_act_s   = ret & RAS_ON;

    // Next-PC priority: trap > eret(HANDLER) > stall > ret > jump > branch > increment.
    always_comb begin
        pc_nxt_s    = pc_plus_s;
        epc_nxt_s   = epc_r;
        state_nxt_s = state_r;
        mis_nxt_s   = 1'b0;
        df_nxt_s    = 1'b0;
        rerr_nxt_s  = 1'b0;
        push_s      = 1'b0;
        pop_s       = 1'b0;
        take_trap_s = 1'b0;
        if (trap) begin
            take_trap_s = 1'b1;
        end else if (eret && (state_r == ST_HANDLER)) begin
            pc_nxt_s    = epc_r;
            state_nxt_s = ST_RUN;
        end else if (stall) begin
            pc_nxt_s = pc_r;
        end else if (ret_act_s) begin
            if (ras_empty_s) begin
                rerr_nxt_s = 1'b1;
            end else if (is_misaligned(ras_top_s)) begin
                take_trap_s = 1'b1;
                mis_nxt_s   = 1'b1;
            end else begin
                pc_nxt_s = ras_top_s;
                pop_s    = 1'b1;
            end
        end else if (jmp_valid) begin
            if (is_misaligned(jmp_target)) begin
                take_trap_s = 1'b1;
                mis_nxt_s   = 1'b1;
            end else begin
                pc_nxt_s = jmp_target;
                push_s   = call & RAS_ON;
            end
        end else if (br_taken) begin
            if (is_misaligned(br_target_s)) begin
                take_trap_s = 1'b1;
                mis_nxt_s   = 1'b1;
            end else begin
                pc_nxt_s = br_target_s;
            end
        end else begin
            pc_nxt_s = pc_plus_s;
        end

        // A misaligned redirect follows exactly the same state rules as an explicit trap.
        if (take_trap_s) begin
            pc_nxt_s = TRAP_VEC;
            case (state_r)
                ST_RUN: begin
                    epc_nxt_s   = pc_r;
                    state_nxt_s = ST_HANDLER;
                end
                ST_HANDLER: df_nxt_s = 1'b1;
                default: begin
                    epc_nxt_s   = pc_r;
                    state_nxt_s = ST_HANDLER;
                end
            endcase
        end else begin
            epc_nxt_s = epc_nxt_s;
        end
    end

    // PC, EPC, trap state and status pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r    <= RESET_VEC;
            epc_r   <= {N{1'b0}};
            state_r <= ST_RUN;
            mis_r   <= 1'b0;
            df_r    <= 1'b0;
            rerr_r  <= 1'b0;
        end else begin
            pc_r    <= pc_nxt_s;
            epc_r   <= epc_nxt_s;
            state_r <= state_nxt_s;
            mis_r   <= mis_nxt_s;
            df_r    <= df_nxt_s;
            rerr_r  <= rerr_nxt_s;
        end
    end

`ifdef PC_RAS_EN
    localparam int PW = $clog2(RAS_DEPTH);

    logic [N-1:0] ras_mem_r [RAS_DEPTH];
    logic [PW-1:0] sp_r;
    logic [PW:0]   cnt_r;
    logic          empty_r;

    assign ras_top_s   = ras_mem_r[sp_r - PW'(1)];
    assign ras_empty_s = empty_r;

    // Circular stack: sp_r points at the next free slot, so a push when full overwrites the oldest entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RAS_DEPTH; i++) begin
                ras_mem_r[i] <= {N{1'b0}};
            end
            sp_r    <= {PW{1'b0}};
            cnt_r   <= {(PW+1){1'b0}};
            empty_r <= 1'b1;
        end else if (push_s) begin
            ras_mem_r[sp_r] <= pc_plus_s;
            sp_r            <= sp_r + PW'(1);
            empty_r         <= 1'b0;
            if (cnt_r != (PW+1)'(RAS_DEPTH)) begin
                cnt_r <= cnt_r + (PW+1)'(1);
            end else begin
                cnt_r <= cnt_r;
            end
        end else if (pop_s) begin
            sp_r    <= sp_r - PW'(1);
            cnt_r   <= cnt_r - (PW+1)'(1);
            empty_r <= (cnt_r == (PW+1)'(1));
        end else begin
            sp_r    <= sp_r;
            cnt_r   <= cnt_r;
            empty_r <= empty_r;
        end
    end
`else
    assign ras_top_s   = {N{1'b0}};
    assign ras_empty_s = 1'b1;
    logic unused_ras_s;
    assign unused_ras_s = ^{push_s, pop_s, ras_top_s};
`endif

    assign pc           = pc_r;
    assign pc_plus      = pc_plus_s;
    assign epc          = epc_r;
    assign in_handler   = (state_r == ST_HANDLER);
    assign misaligned   = mis_r;
    assign double_fault = df_r;
    assign ras_empty    = ras_empty_s;
    assign ras_err      = rerr_r;

endmodule

// File: tb/tb_pc_unit.sv
// Directed scoreboard bench for pc_unit; RAS steps are compiled in when PC_RAS_EN is defined.
module tb_pc_unit;

    logic        clk = 1'b0;
    logic        rst_n, stall, br_taken, jmp_valid, call, ret, trap, eret;
    logic [31:0] br_offset, jmp_target;
    logic [31:0] pc, pc_plus, epc;
    logic        in_handler, misaligned, double_fault, ras_empty, ras_err;

    int vectors = 0;
    int errors  = 0;

    typedef struct {
        string       tag;
        logic [31:0] pc;
        logic [31:0] epc;
        logic        ih;
        logic [2:0]  flags;
        logic        remp;
    } exp_t;

    exp_t sb[$];

    pc_unit dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .br_taken(br_taken), .br_offset(br_offset),
        .jmp_valid(jmp_valid), .jmp_target(jmp_target), .call(call), .ret(ret), .trap(trap),
        .eret(eret), .pc(pc), .pc_plus(pc_plus), .epc(epc), .in_handler(in_handler),
        .misaligned(misaligned), .double_fault(double_fault), .ras_empty(ras_empty), .ras_err(ras_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, vectors=%0d", vectors);
        $fatal(1, "watchdog");
    end

    task automatic clear_inputs();
        stall = 1'b0; br_taken = 1'b0; jmp_valid = 1'b0; call = 1'b0;
        ret = 1'b0; trap = 1'b0; eret = 1'b0; br_offset = 32'h0; jmp_target = 32'h0;
    endtask

    task automatic check(input exp_t e);
        vectors++;
        assert (pc === e.pc) else begin
            errors++; $error("FAIL %s pc observed=%h expected=%h", e.tag, pc, e.pc);
        end
        vectors++;
        assert (epc === e.epc) else begin
            errors++; $error("FAIL %s epc observed=%h expected=%h", e.tag, epc, e.epc);
        end
        vectors++;
        assert (in_handler === e.ih) else begin
            errors++; $error("FAIL %s in_handler observed=%b expected=%b", e.tag, in_handler, e.ih);
        end
        vectors++;
        assert ({misaligned, double_fault, ras_err} === e.flags) else begin
            errors++; $error("FAIL %s mis/df/rerr observed=%b expected=%b", e.tag,
                             {misaligned, double_fault, ras_err}, e.flags);
        end
        vectors++;
        assert (ras_empty === e.remp) else begin
            errors++; $error("FAIL %s ras_empty observed=%b expected=%b", e.tag, ras_empty, e.remp);
        end
    endtask

    // Push the expectation for the inputs currently driven, clock once, then pop and compare.
    task automatic step(input string tag, input logic [31:0] p, input logic [31:0] e,
                        input logic ih, input logic [2:0] flags, input logic remp);
        exp_t x;
        x.tag = tag; x.pc = p; x.epc = e; x.ih = ih; x.flags = flags; x.remp = remp;
        sb.push_back(x);
        @(posedge clk);
        #1;
        clear_inputs();
        x = sb.pop_front();
        check(x);
    endtask

    task automatic jump(input logic [31:0] t, input logic [31:0] e);
        jmp_valid = 1'b1; jmp_target = t;
        step("jump", t, e, 1'b0, 3'b000, 1'b1);
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        #2;
        check('{tag: "reset", pc: 32'h0, epc: 32'h0, ih: 1'b0, flags: 3'b000, remp: 1'b1});
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step("idle1", 32'h4, 32'h0, 1'b0, 3'b000, 1'b1);
        step("idle2", 32'h8, 32'h0, 1'b0, 3'b000, 1'b1);
        step("idle3", 32'hC, 32'h0, 1'b0, 3'b000, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check('{tag: "async_reset", pc: 32'h0, epc: 32'h0, ih: 1'b0, flags: 3'b000, remp: 1'b1});
        #1 rst_n = 1'b1;
        step("post_reset", 32'h4, 32'h0, 1'b0, 3'b000, 1'b1);

        jump(32'h20, 32'h0);
        br_taken = 1'b1; br_offset = -32'sd8;
        step("branch_back", 32'h18, 32'h0, 1'b0, 3'b000, 1'b1);
        stall = 1'b1;
        step("stall1", 32'h18, 32'h0, 1'b0, 3'b000, 1'b1);
        stall = 1'b1; jmp_valid = 1'b1; jmp_target = 32'h80;
        step("stall_over_jump", 32'h18, 32'h0, 1'b0, 3'b000, 1'b1);

        jump(32'h40, 32'h0);
        trap = 1'b1;
        step("trap", 32'h100, 32'h40, 1'b1, 3'b000, 1'b1);
        trap = 1'b1;
        step("double_fault", 32'h100, 32'h40, 1'b1, 3'b010, 1'b1);
        step("handler_idle", 32'h104, 32'h40, 1'b1, 3'b000, 1'b1);
        eret = 1'b1;
        step("eret", 32'h40, 32'h40, 1'b0, 3'b000, 1'b1);

        jump(32'h50, 32'h40);
        jmp_valid = 1'b1; jmp_target = 32'h62;
        step("misaligned_jump", 32'h100, 32'h50, 1'b1, 3'b100, 1'b1);
        eret = 1'b1;
        step("eret_mis", 32'h50, 32'h50, 1'b0, 3'b000, 1'b1);
        br_taken = 1'b1; br_offset = 32'h6;
        step("misaligned_branch", 32'h100, 32'h50, 1'b1, 3'b100, 1'b1);
        eret = 1'b1;
        step("eret_mis_br", 32'h50, 32'h50, 1'b0, 3'b000, 1'b1);
        jump(32'h0, 32'h50);
        eret = 1'b1;
        step("run_eret_ignored", 32'h4, 32'h50, 1'b0, 3'b000, 1'b1);

        trap = 1'b1; stall = 1'b1;
        step("trap_under_stall", 32'h100, 32'h4, 1'b1, 3'b000, 1'b1);
        eret = 1'b1; stall = 1'b1;
        step("eret_under_stall", 32'h4, 32'h4, 1'b0, 3'b000, 1'b1);

        jump(32'hFFFF_FFFC, 32'h4);
        step("wrap_inc", 32'h0, 32'h4, 1'b0, 3'b000, 1'b1);
        br_taken = 1'b1; br_offset = -32'sd4;
        step("wrap_branch", 32'hFFFF_FFFC, 32'h4, 1'b0, 3'b000, 1'b1);
        step("wrap_inc2", 32'h0, 32'h4, 1'b0, 3'b000, 1'b1);

`ifdef PC_RAS_EN
        jump(32'h10, 32'h4);
        jmp_valid = 1'b1; jmp_target = 32'h200; call = 1'b1;
        step("call1", 32'h200, 32'h4, 1'b0, 3'b000, 1'b0);
        jmp_valid = 1'b1; jmp_target = 32'h300; call = 1'b1;
        step("call2", 32'h300, 32'h4, 1'b0, 3'b000, 1'b0);
        ret = 1'b1;
        step("ret1", 32'h204, 32'h4, 1'b0, 3'b000, 1'b0);
        ret = 1'b1;
        step("ret2", 32'h14, 32'h4, 1'b0, 3'b000, 1'b1);
        ret = 1'b1;
        step("ret_empty", 32'h18, 32'h4, 1'b0, 3'b001, 1'b1);
        step("rerr_pulse_end", 32'h1C, 32'h4, 1'b0, 3'b000, 1'b1);

        for (int i = 0; i < 5; i++) begin
            jmp_valid = 1'b1; jmp_target = 32'h400 + 32'h100 * i; call = 1'b1;
            step("call_fill", 32'h400 + 32'h100 * i, 32'h4, 1'b0, 3'b000, 1'b0);
        end
        for (int i = 4; i >= 1; i--) begin
            ret = 1'b1;
            step("ret_newest", 32'h304 + 32'h100 * i, 32'h4, 1'b0, 3'b000, (i == 1) ? 1'b1 : 1'b0);
        end
        ret = 1'b1;
        step("ret_after_drain", 32'h408, 32'h4, 1'b0, 3'b001, 1'b1);
        ret = 1'b1; call = 1'b1; jmp_valid = 1'b1; jmp_target = 32'h900;
        step("call_ret_ret_wins", 32'h40C, 32'h4, 1'b0, 3'b001, 1'b1);
`else
        jmp_valid = 1'b1; jmp_target = 32'h40; call = 1'b1;
        step("call_plain_jump", 32'h40, 32'h4, 1'b0, 3'b000, 1'b1);
        ret = 1'b1;
        step("ret_ignored", 32'h44, 32'h4, 1'b0, 3'b000, 1'b1);
        ret = 1'b1; br_taken = 1'b1; br_offset = 32'h8;
        step("ret_falls_to_branch", 32'h4C, 32'h4, 1'b0, 3'b000, 1'b1);
`endif

        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
